// File: rtl/reed_pkg.sv
// Shared state encoding and sizing helpers for the reed-switch zone alarm.
package reed_pkg;

  localparam int unsigned STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    DISARMED    = 3'd0,
    EXIT_DELAY  = 3'd1,
    ARMED       = 3'd2,
    ENTRY_DELAY = 3'd3,
    ALARM       = 3'd4
  } state_t;

  // Largest of three cycle counts; sizes the shared FSM timer.
  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Bits needed to hold values 0..v (at least one bit).
  function automatic int unsigned cnt_w(input int unsigned v);
    int unsigned w;
    w = $clog2(64'(v) + 64'd1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/reed_alarm_ctrl_if.sv
// Zone inputs, arm/disarm requests and board-facing outputs of the alarm sequencer.
interface reed_alarm_ctrl_if import reed_pkg::*; #(
  parameter int unsigned N_ZONES = 4
);

  logic               arm_req;
  logic               disarm_req;
  logic [N_ZONES-1:0] zone_closed;
  logic [STATE_W-1:0] state;
  logic               armed;
  logic               siren;
  logic               arm_fail;
  logic [N_ZONES-1:0] tripped;
  logic               chime;

  modport master (
    output arm_req, disarm_req, zone_closed,
    input  state, armed, siren, arm_fail, tripped, chime
  );

  modport slave (
    input  arm_req, disarm_req, zone_closed,
    output state, armed, siren, arm_fail, tripped, chime
  );

endinterface

// File: rtl/alarm_timer.sv
// Loadable down-counter; holds at zero, done flags a zero count.
module alarm_timer #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         done
);

  logic [W-1:0] count;

  // Load has priority; counting stops at zero so expiry never wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/reed_alarm_ctrl.sv
// Zone-alarm sequencer: arm / exit delay / armed / entry delay / alarm.
// Optional door chime in DISARMED is built when CHIME_EN is defined.
module reed_alarm_ctrl import reed_pkg::*; #(
  parameter int unsigned        N_ZONES         = 4,
  parameter logic [N_ZONES-1:0] ENTRY_MASK      = N_ZONES'(1),
  parameter int unsigned        EXIT_DELAY_CYC  = 32'd1_000_000_000,
  parameter int unsigned        ENTRY_DELAY_CYC = 32'd1_500_000_000,
  parameter int unsigned        SIREN_CYC       = 32'd3_000_000_000,
  parameter int unsigned        CHIME_CYC       = 32'd10_000_000
) (
  input  logic clk,
  input  logic rst,
  reed_alarm_ctrl_if.slave bus
);

  localparam int unsigned TMR_W = cnt_w(max3(EXIT_DELAY_CYC, ENTRY_DELAY_CYC, SIREN_CYC));
  localparam logic [TMR_W-1:0] EXIT_LD  = TMR_W'(EXIT_DELAY_CYC - 1);
  localparam logic [TMR_W-1:0] ENTRY_LD = TMR_W'(ENTRY_DELAY_CYC - 1);
  localparam logic [TMR_W-1:0] SIREN_LD = TMR_W'(SIREN_CYC - 1);

  // Reject configurations the sequencer cannot represent.
  if ((N_ZONES < 1) || (N_ZONES > 16) || (EXIT_DELAY_CYC < 1) || (ENTRY_DELAY_CYC < 1) ||
      (SIREN_CYC < 1) || (CHIME_CYC < 1)) begin : g_bad_params
    $error("reed_alarm_ctrl: parameter out of range");
  end

  state_t             state_q, state_n;
  logic               armed_q, armed_n;
  logic               siren_q, siren_n;
  logic               arm_fail_q, arm_fail_n;
  logic [N_ZONES-1:0] tripped_q, tripped_n;
  logic               tmr_load;
  logic [TMR_W-1:0]   tmr_val;
  logic               tmr_done;

  logic [N_ZONES-1:0] zone_open;
  logic               all_closed, inst_open, ent_open;

  assign zone_open  = ~bus.zone_closed;
  assign all_closed = &bus.zone_closed;
  assign inst_open  = |(zone_open & ~ENTRY_MASK);
  assign ent_open   = |(zone_open & ENTRY_MASK);

  // Shared timer for exit delay, entry delay and siren duration.
  alarm_timer #(.W(TMR_W)) u_fsm_tmr (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .en       (1'b1),
    .done     (tmr_done)
  );

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= DISARMED;
      armed_q    <= 1'b0;
      siren_q    <= 1'b0;
      arm_fail_q <= 1'b0;
      tripped_q  <= '0;
    end else begin
      state_q    <= state_n;
      armed_q    <= armed_n;
      siren_q    <= siren_n;
      arm_fail_q <= arm_fail_n;
      tripped_q  <= tripped_n;
    end
  end

  // Next state, timer loads and next output values; disarm beats arm beats zones.
  always_comb begin
    state_n    = state_q;
    siren_n    = 1'b0;
    arm_fail_n = 1'b0;
    tripped_n  = tripped_q;
    tmr_load   = 1'b0;
    tmr_val    = '0;

    case (state_q)
      DISARMED: begin
        if (!bus.disarm_req && bus.arm_req) begin
          if (all_closed) begin
            state_n   = EXIT_DELAY;
            tripped_n = '0;
            tmr_load  = 1'b1;
            tmr_val   = EXIT_LD;
          end else begin
            arm_fail_n = 1'b1;
          end
        end
      end

      EXIT_DELAY: begin
        if (bus.disarm_req) begin
          state_n = DISARMED;
        end else if (tmr_done) begin
          if (all_closed) begin
            state_n = ARMED;
          end else begin
            state_n    = DISARMED;
            arm_fail_n = 1'b1;
          end
        end
      end

      ARMED: begin
        if (bus.disarm_req) begin
          state_n = DISARMED;
        end else begin
          tripped_n = tripped_q | zone_open;
          if (inst_open) begin
            state_n  = ALARM;
            siren_n  = 1'b1;
            tmr_load = 1'b1;
            tmr_val  = SIREN_LD;
          end else if (ent_open) begin
            state_n  = ENTRY_DELAY;
            tmr_load = 1'b1;
            tmr_val  = ENTRY_LD;
          end
        end
      end

      ENTRY_DELAY: begin
        if (bus.disarm_req) begin
          state_n = DISARMED;
        end else begin
          tripped_n = tripped_q | zone_open;
          if (inst_open || tmr_done) begin
            state_n  = ALARM;
            siren_n  = 1'b1;
            tmr_load = 1'b1;
            tmr_val  = SIREN_LD;
          end
        end
      end

      ALARM: begin
        if (bus.disarm_req) begin
          state_n = DISARMED;
        end else begin
          tripped_n = tripped_q | zone_open;
          // Siren runs once per alarm; the last high cycle is the one at count zero.
          siren_n   = siren_q && !tmr_done;
        end
      end

      default: state_n = DISARMED;
    endcase

    armed_n = (state_n != DISARMED);
  end

  assign bus.state    = state_q;
  assign bus.armed    = armed_q;
  assign bus.siren    = siren_q;
  assign bus.arm_fail = arm_fail_q;
  assign bus.tripped  = tripped_q;

`ifdef CHIME_EN
  localparam int unsigned CHM_W = cnt_w(CHIME_CYC);

  logic [N_ZONES-1:0] zone_q;
  logic               chime_q, chime_n;
  logic               chm_load, chm_done;

  // Independent chime counter so the FSM timer is never disturbed.
  alarm_timer #(.W(CHM_W)) u_chime_tmr (
    .clk      (clk),
    .rst      (rst),
    .load     (chm_load),
    .load_val (CHM_W'(CHIME_CYC - 1)),
    .en       (1'b1),
    .done     (chm_done)
  );

  // Previous zone sample for per-bit open-edge detection, plus chime output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      zone_q  <= '0;
      chime_q <= 1'b0;
    end else begin
      zone_q  <= bus.zone_closed;
      chime_q <= chime_n;
    end
  end

  // Any closed->open edge while disarmed (re)starts the pulse; leaving DISARMED kills it.
  always_comb begin
    chm_load = 1'b0;
    chime_n  = chime_q && !chm_done;
    if (state_n != DISARMED) begin
      chime_n = 1'b0;
    end else if ((state_q == DISARMED) && |(zone_q & ~bus.zone_closed)) begin
      chime_n  = 1'b1;
      chm_load = 1'b1;
    end
  end

  assign bus.chime = chime_q;
`else
  assign bus.chime = 1'b0;
`endif

endmodule

// File: tb/tb_reed_alarm_ctrl.sv
// Directed and randomized checks of reed_alarm_ctrl against a cycle-level reference model.
module tb_reed_alarm_ctrl;

  localparam int unsigned NZ    = 2;
  localparam logic [1:0]  MASK  = 2'b01;
  localparam int          EXIT  = 8;
  localparam int          ENTRY = 5;
  localparam int          SIREN = 6;
  localparam int          CHIME = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  reed_alarm_ctrl_if #(.N_ZONES(NZ)) bus ();

  reed_alarm_ctrl #(
    .N_ZONES         (NZ),
    .ENTRY_MASK      (MASK),
    .EXIT_DELAY_CYC  (EXIT),
    .ENTRY_DELAY_CYC (ENTRY),
    .SIREN_CYC       (SIREN),
    .CHIME_CYC       (CHIME)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: mode number, cycles left in timed mode, siren/chime cycles left.
  int         m_state;
  int         m_left;
  int         m_siren;
  int         m_chime;
  logic [1:0] m_trip;
  bit         m_fail;
`ifdef CHIME_EN
  logic [1:0] m_zprev;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0;
    m_left  = 0;
    m_siren = 0;
    m_chime = 0;
    m_trip  = 2'b00;
    m_fail  = 1'b0;
`ifdef CHIME_EN
    m_zprev = 2'b00;
`endif
  endtask

  // One clock of the alarm rules applied to the inputs sampled at that edge.
  task automatic model_step(input bit a, input bit d, input logic [1:0] z);
    int         nxt;
    logic [1:0] opn;
    bit         allc, inst, ent;
    opn    = ~z;
    allc   = (z == 2'b11);
    inst   = |(opn & ~MASK);
    ent    = |(opn & MASK);
    nxt    = m_state;
    m_fail = 1'b0;
    if (d) begin
      nxt     = 0;
      m_siren = 0;
    end else begin
      case (m_state)
        0: if (a) begin
             if (allc) begin nxt = 1; m_left = EXIT; m_trip = 2'b00; end
             else m_fail = 1'b1;
           end
        1: begin
             m_left--;
             if (m_left == 0) begin
               if (allc) nxt = 2;
               else begin nxt = 0; m_fail = 1'b1; end
             end
           end
        2: begin
             m_trip |= opn;
             if (inst) begin nxt = 4; m_siren = SIREN; end
             else if (ent) begin nxt = 3; m_left = ENTRY; end
           end
        3: begin
             m_trip |= opn;
             m_left--;
             if (inst || (m_left == 0)) begin nxt = 4; m_siren = SIREN; end
           end
        default: begin
             m_trip |= opn;
             if (m_siren > 0) m_siren--;
           end
      endcase
    end
`ifdef CHIME_EN
    if (nxt != 0) m_chime = 0;
    else if ((m_state == 0) && |(m_zprev & ~z)) m_chime = CHIME;
    else if (m_chime > 0) m_chime--;
    m_zprev = z;
`endif
    m_state = nxt;
  endtask

  task automatic check_all();
    chk("state",    32'(bus.state),    32'(m_state));
    chk("armed",    32'(bus.armed),    32'(m_state != 0));
    chk("siren",    32'(bus.siren),    32'((m_state == 4) && (m_siren > 0)));
    chk("arm_fail", 32'(bus.arm_fail), 32'(m_fail));
    chk("tripped",  32'(bus.tripped),  32'(m_trip));
    chk("chime",    32'(bus.chime),    32'(m_chime > 0));
  endtask

  // Advance one clock, update the model with the sampled inputs, compare everything.
  task automatic step();
    bit         a, d;
    logic [1:0] z;
    a = bus.arm_req;
    d = bus.disarm_req;
    z = bus.zone_closed;
    @(posedge clk);
    #1;
    model_step(a, d, z);
    check_all();
  endtask

  task automatic pulse_arm();
    bus.arm_req = 1'b1;
    step();
    bus.arm_req = 1'b0;
  endtask

  task automatic pulse_disarm();
    bus.disarm_req = 1'b1;
    step();
    bus.disarm_req = 1'b0;
  endtask

  task automatic arm_to_armed();
    bus.zone_closed = 2'b11;
    pulse_arm();
    repeat (EXIT) step();
    chk("reach_armed", 32'(bus.state), 32'd2);
  endtask

  initial begin
    bus.arm_req     = 1'b0;
    bus.disarm_req  = 1'b0;
    bus.zone_closed = 2'b11;
    model_reset();
    #12;
    chk("rst_state",   32'(bus.state),   32'd0);
    chk("rst_armed",   32'(bus.armed),   32'd0);
    chk("rst_siren",   32'(bus.siren),   32'd0);
    chk("rst_tripped", 32'(bus.tripped), 32'd0);
    chk("rst_chime",   32'(bus.chime),   32'd0);
    rst = 1'b0;

    // Arm with all zones closed, exit delay of exactly EXIT cycles.
    step();
    pulse_arm();
    chk("t1_exit_state", 32'(bus.state), 32'd1);
    chk("t1_exit_armed", 32'(bus.armed), 32'd1);
    repeat (EXIT - 1) step();
    chk("t1_exit_last", 32'(bus.state), 32'd1);
    step();
    chk("t1_armed",   32'(bus.state),   32'd2);
    chk("t1_tripped", 32'(bus.tripped), 32'd0);

    // Entry zone opens: entry delay, alarm, siren window, disarm keeps tripped.
    bus.zone_closed = 2'b10;
    step();
    chk("t2_entry",   32'(bus.state),   32'd3);
    chk("t2_tripped", 32'(bus.tripped), 32'd1);
    repeat (ENTRY - 1) step();
    chk("t2_entry_last", 32'(bus.state), 32'd3);
    step();
    chk("t2_alarm", 32'(bus.state), 32'd4);
    chk("t2_siren_on", 32'(bus.siren), 32'd1);
    repeat (SIREN - 1) begin
      step();
      chk("t2_siren_hold", 32'(bus.siren), 32'd1);
    end
    step();
    chk("t2_siren_off", 32'(bus.siren), 32'd0);
    chk("t2_alarm_hold", 32'(bus.state), 32'd4);
    pulse_disarm();
    chk("t2_disarmed", 32'(bus.state),   32'd0);
    chk("t2_tripped_kept", 32'(bus.tripped), 32'd1);

    // Instant zone goes straight to alarm.
    arm_to_armed();
    bus.zone_closed = 2'b01;
    step();
    chk("t3_instant", 32'(bus.state),   32'd4);
    chk("t3_trip",    32'(bus.tripped), 32'd2);
    pulse_disarm();
    // Instant zone during entry delay cuts it short.
    arm_to_armed();
    bus.zone_closed = 2'b10;
    step();
    step();
    step();
    bus.zone_closed = 2'b00;
    step();
    chk("t3_entry_cut", 32'(bus.state),   32'd4);
    chk("t3_trip_both", 32'(bus.tripped), 32'd3);
    pulse_disarm();
    bus.zone_closed = 2'b11;
    step();

    // Rejected arm, then arm that fails at exit expiry.
    bus.zone_closed = 2'b10;
    pulse_arm();
    chk("t4_fail_pulse", 32'(bus.arm_fail), 32'd1);
    chk("t4_fail_state", 32'(bus.state),    32'd0);
    step();
    chk("t4_fail_clear", 32'(bus.arm_fail), 32'd0);
    bus.zone_closed = 2'b11;
    pulse_arm();
    repeat (EXIT - 2) step();
    bus.zone_closed = 2'b10;
    step();
    chk("t4_exit_open", 32'(bus.state), 32'd1);
    step();
    chk("t4_exit_fail", 32'(bus.arm_fail), 32'd1);
    chk("t4_exit_back", 32'(bus.state),    32'd0);
    chk("t4_trip_clr",  32'(bus.tripped),  32'd0);
    step();

    // Simultaneous arm and disarm: disarm wins, nothing happens.
    bus.zone_closed = 2'b11;
    bus.arm_req     = 1'b1;
    bus.disarm_req  = 1'b1;
    step();
    bus.arm_req     = 1'b0;
    bus.disarm_req  = 1'b0;
    chk("t5_both_state", 32'(bus.state),    32'd0);
    chk("t5_both_fail",  32'(bus.arm_fail), 32'd0);
    // Asynchronous reset in the middle of entry delay.
    arm_to_armed();
    bus.zone_closed = 2'b10;
    step();
    step();
    rst = 1'b1;
    #1;
    model_reset();
    chk("t5_rst_state",   32'(bus.state),   32'd0);
    chk("t5_rst_siren",   32'(bus.siren),   32'd0);
    chk("t5_rst_tripped", 32'(bus.tripped), 32'd0);
    chk("t5_rst_armed",   32'(bus.armed),   32'd0);
    @(negedge clk);
    rst = 1'b0;
    bus.zone_closed = 2'b11;
    step();

    // Chime on a zone opening while disarmed, restarted by a second edge.
    bus.zone_closed = 2'b10;
    step();
`ifdef CHIME_EN
    chk("t6_chime_c1", 32'(bus.chime), 32'd1);
    step();
    chk("t6_chime_c2", 32'(bus.chime), 32'd1);
    bus.zone_closed = 2'b00;
    step();
    chk("t6_restart_c1", 32'(bus.chime), 32'd1);
    step();
    step();
    chk("t6_restart_c3", 32'(bus.chime), 32'd1);
    step();
    chk("t6_chime_end", 32'(bus.chime), 32'd0);
`else
    chk("t6_no_chime", 32'(bus.chime), 32'd0);
    step();
    chk("t6_no_chime2", 32'(bus.chime), 32'd0);
`endif
    bus.zone_closed = 2'b11;
    step();

    // Randomized traffic checked cycle by cycle against the model.
    repeat (3000) begin
      bus.arm_req    = ($urandom_range(0, 7) == 0);
      bus.disarm_req = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 5) == 0) begin
        bus.zone_closed = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
      end
      step();
    end
    bus.arm_req    = 1'b0;
    bus.disarm_req = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/reed_alarm_ctrl.md
Name: reed_alarm_ctrl

Overview:
Zone-alarm sequencer for debounced reed-switch inputs. Each zone bit comes from an upstream per-zone synchronizer/debouncer. 1 = magnet present (door/window closed), 0 = open.
The block runs the arm / exit-delay / armed / entry-delay / alarm sequence and drives the siren, the armed LED and a latched record of which zones tripped.
It sits between the debouncers and the board outputs (LEDs, siren driver).

Parameters:
N_ZONES, 4, number of reed zones (1..16)
ENTRY_MASK, 4'b0001, bit i = 1: zone i is an entry zone (delayed alarm); 0: instant zone
EXIT_DELAY_CYC, 1_000_000_000, cycles of exit delay after an accepted arm
ENTRY_DELAY_CYC, 1_500_000_000, cycles allowed to disarm after an entry zone opens
SIREN_CYC, 3_000_000_000, cycles the siren stays on per alarm
CHIME_CYC, 10_000_000, chime pulse length (used only with CHIME_EN)

Ports:
clk  in  1  system clock; all state on rising edge
rst  in  1  asynchronous, active-high reset
arm_req  in  1  single-cycle arm request
disarm_req  in  1  single-cycle disarm request
zone_closed  in  N_ZONES  debounced zone states, 1 = closed
state  out  3  current FSM state encoding
armed  out  1  1 in EXIT_DELAY, ARMED, ENTRY_DELAY, ALARM
siren  out  1  siren drive
arm_fail  out  1  one-cycle pulse when an arm attempt is rejected
tripped  out  N_ZONES  sticky mask of zones that caused entry/alarm
chime  out  1  door chime (0 without CHIME_EN)

Behaviour:
- Reset (async assert, sync-free release):
  - state = DISARMED; all outputs 0; timer = 0; tripped = 0.
- Encodings: DISARMED=0, EXIT_DELAY=1, ARMED=2, ENTRY_DELAY=3, ALARM=4. Values 5..7 recover to DISARMED on the next cycle.
- Registered FSM. Outputs change the cycle after the causing input is sampled.
- Timer:
  - One shared down-counter, width $clog2(max delay param + 1).
  - Entering a timed state loads the counter with DELAY-1. It decrements each cycle.
  - Expiry = counter == 0 while in that state, so the state lasts exactly DELAY cycles. Expiry never wraps below 0.
- Priority everywhere: disarm_req > arm_req > zone events. Simultaneous arm_req and disarm_req = disarm.
- Let all_closed = &zone_closed, inst_open = |(~zone_closed & ~ENTRY_MASK), ent_open = |(~zone_closed & ENTRY_MASK).
- DISARMED:
  - arm_req with all_closed -> EXIT_DELAY; clear tripped.
  - arm_req without all_closed -> stay; arm_fail = 1 for one cycle.
- EXIT_DELAY:
  - Zones may open freely.
  - disarm_req -> DISARMED.
  - On expiry: all_closed -> ARMED; otherwise arm_fail pulse and -> DISARMED.
- ARMED:
  - disarm_req -> DISARMED.
  - inst_open -> ALARM.
  - else ent_open -> ENTRY_DELAY.
  - Open zones are OR'd into tripped.
- ENTRY_DELAY:
  - disarm_req -> DISARMED.
  - inst_open -> ALARM immediately.
  - Expiry -> ALARM.
  - Newly opened zones are OR'd into tripped.
- ALARM:
  - siren = 1 for SIREN_CYC cycles from entry, then 0.
  - State stays ALARM until disarm_req. Further openings are still OR'd into tripped. No re-trigger of siren.
  - disarm_req -> DISARMED, siren 0 the next cycle.
- tripped persists through DISARMED so it can be read after disarm. It clears only on rst or an accepted arm.
- arm_req while not DISARMED is ignored (no arm_fail).

Optional Feature:
- Macro CHIME_EN.
- Defined: in DISARMED only, a 1->0 transition of any zone_closed bit (per-bit registered compare) starts a chime pulse of CHIME_CYC cycles.
  - A new edge during a pulse restarts it.
  - The chime uses its own counter, separate from the FSM timer.
  - Leaving DISARMED forces chime 0.
- Undefined: chime tied to 0; no edge registers or chime counter synthesized.

Decomposition:
- Package reed_pkg: state typedef/localparams (DISARMED..ALARM), STATE_W = 3.
- Sub-module alarm_timer: loadable down-counter with parameter W, inputs load/load_val/en, output done (count == 0). Instantiated for the FSM timer and, under CHIME_EN, the chime counter.

Test Plan:
(Bench params: N_ZONES=2, ENTRY_MASK=2'b01, EXIT=8, ENTRY=5, SIREN=6, CHIME=3.)
1. zone_closed=2'b11, arm_req pulse -> state=1 next cycle, armed=1; 8 cycles later state=2; tripped=0.
2. Armed, zone_closed->2'b10 -> state=3, tripped=2'b01; no disarm -> state=4 exactly 5 cycles after entering 3; siren high 6 cycles then low; state stays 4 until disarm_req -> state=0, tripped still 2'b01.
3. Armed, zone_closed->2'b01 (instant zone) -> state=4 in 1 cycle, tripped=2'b10; also in ENTRY_DELAY, opening zone1 at delay cycle 2 -> ALARM next cycle, tripped=2'b11.
4. zone_closed=2'b10 in DISARMED, arm_req -> arm_fail one cycle, state 0. Arm accepted, zone0 open at EXIT expiry -> arm_fail, state 0.
5. arm_req and disarm_req same cycle in DISARMED -> no transition. rst asserted mid ENTRY_DELAY -> state=0, siren=0, tripped=0 immediately (asynchronous).
6. CHIME_EN: DISARMED, zone0 1->0 -> chime high 3 cycles; second edge at cycle 2 -> chime extended to 3 cycles from that edge. Without macro, chime stays 0.
